mem_datos_be: RTL and testbench

//  Parametrised byte-addressable data memory for the single-cycle/pipelined core.

---
 rtl/mem_datos_be.sv | 183 ++++++++++++++++++
 tb/tb_mem_datos_be.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_datos_be.sv
// ============================================================================
// Module  : mem_datos_be
// Brief   : Byte-addressable data memory with sized loads/stores, sign or zero
//           extension, registered response and a post-reset clear sweep.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_datos_be #(
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = 32,
   parameter int INIT_CLR = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [1:0]        size_i,
   input  logic              sign_ext_i,
   input  logic [31:0]       wdata_i,
   output logic              rsp_valid_o,
   output logic [31:0]       rdata_o,
   output logic              err_o,
   output logic              init_done_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           state_q;
   logic [IDX_W-1:0] clr_ptr_q;
   logic             req_ready_q;
   logic             rsp_valid_q;
   logic [31:0]      rdata_q;
   logic             err_q;
   logic             init_done_q;
   logic [31:0]      mem_q [DEPTH];

   logic [IDX_W-1:0] idx;
   logic [1:0]       lane;
   logic             oor;
   logic             err_req;
   logic             accept;
   logic             st_en;
   logic             clr_en;
   logic [3:0]       byte_en;
   logic [31:0]      wlanes;
   logic [31:0]      rd_word;
   logic [31:0]      rd_shift;
   logic [15:0]      rd_half;
   logic [31:0]      ld_ext;
   logic [31:0]      rdata_d;
   logic             err_d;

   assign idx  = addr_i[IDX_W+1:2];
   assign lane = addr_i[1:0];

   // Any address bit above the word index makes the request out of range.
   if (ADDR_W > IDX_W + 2) begin : g_range
      assign oor = |addr_i[ADDR_W-1:IDX_W+2];
   end else begin : g_norange
      assign oor = 1'b0;
   end

   always_comb begin
      err_req = oor;
      case (size_i)
         2'b00:   err_req = oor;
         2'b01:   err_req = oor | lane[0];
         2'b10:   err_req = oor | (lane != 2'b00);
         default: err_req = 1'b1;
      endcase
   end

   assign accept = req_valid_i && req_ready_q;
   assign st_en  = accept && we_i && !err_req;
   assign clr_en = (state_q == ST_INIT) && (INIT_CLR != 0);

   always_comb begin
      byte_en = 4'b0000;
      wlanes  = 32'h0;
      case (size_i)
         2'b00: begin
            byte_en = 4'b0001 << lane;
            wlanes  = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            byte_en = lane[1] ? 4'b1100 : 4'b0011;
            wlanes  = {2{wdata_i[15:0]}};
         end
         2'b10: begin
            byte_en = 4'b1111;
            wlanes  = wdata_i;
         end
         default: begin
            byte_en = 4'b0000;
            wlanes  = 32'h0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr_en) begin
         mem_q[clr_ptr_q] <= 32'h0;
      end else if (st_en) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
               mem_q[idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
         end
      end
   end

   // The array is read before the accepting edge, so a store on the previous
   // edge is already visible to a back-to-back load.
   assign rd_word  = mem_q[idx];
   assign rd_shift = rd_word >> {lane, 3'b000};
   assign rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      ld_ext = 32'h0;
      case (size_i)
         2'b00:   ld_ext = {{24{sign_ext_i & rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   ld_ext = {{16{sign_ext_i & rd_half[15]}}, rd_half};
         2'b10:   ld_ext = rd_word;
         default: ld_ext = 32'h0;
      endcase
   end

   assign rdata_d = (accept && !we_i && !err_req) ? ld_ext : 32'h0;
   assign err_d   = accept && err_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_INIT;
         clr_ptr_q   <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= 32'h0;
         err_q       <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         rsp_valid_q <= accept;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         case (state_q)
            ST_INIT: begin
               if ((INIT_CLR == 0) || (clr_ptr_q == C_LAST_IDX)) begin
                  state_q     <= ST_RUN;
                  req_ready_q <= 1'b1;
                  init_done_q <= 1'b1;
               end else begin
                  clr_ptr_q <= clr_ptr_q + 1'b1;
               end
            end
            ST_RUN: begin
               state_q     <= ST_RUN;
               req_ready_q <= 1'b1;
               init_done_q <= 1'b1;
            end
            default: begin
               state_q <= ST_INIT;
            end
         endcase
      end
   end

   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rdata_o     = rdata_q;
   assign err_o       = err_q;
   assign init_done_o = init_done_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_datos_be.sv
// ============================================================================
// Module  : tb_mem_datos_be
// Brief   : Self-checking bench for mem_datos_be with a byte-array model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_datos_be;

   localparam int DEPTH  = 32;
   localparam int ADDR_W = 32;
   localparam int NBYTES = DEPTH * 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid_i = 1'b0;
   logic              req_ready_o;
   logic              we_i = 1'b0;
   logic [ADDR_W-1:0] addr_i = '0;
   logic [1:0]        size_i = 2'b00;
   logic              sign_ext_i = 1'b0;
   logic [31:0]       wdata_i = 32'h0;
   logic              rsp_valid_o;
   logic [31:0]       rdata_o;
   logic              err_o;
   logic              init_done_o;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] mem_b [NBYTES];

   mem_datos_be #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_CLR(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .we_i        (we_i),
      .addr_i      (addr_i),
      .size_i      (size_i),
      .sign_ext_i  (sign_ext_i),
      .wdata_i     (wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rdata_o     (rdata_o),
      .err_o       (err_o),
      .init_done_o (init_done_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic model_err(input logic [31:0] a, input logic [1:0] s);
      if (s == 2'b11) return 1'b1;
      if (a >= NBYTES) return 1'b1;
      if ((a % (32'd1 << s)) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s,
                                              input logic sg);
      int n;
      logic [31:0] v;
      n = 1 << s;
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(mem_b[a + i]) << (8 * i));
      if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NBYTES; i++) mem_b[i] = 8'h00;
   endtask

   // One accepted request; response sampled 1 ns after the accepting edge.
   task automatic do_req(input string tag, input logic w, input logic [31:0] a,
                         input logic [1:0] s, input logic sg, input logic [31:0] d,
                         input logic [31:0] e_rd, input logic e_err);
      @(negedge clk);
      req_valid_i = 1'b1;
      we_i        = w;
      addr_i      = a;
      size_i      = s;
      sign_ext_i  = sg;
      wdata_i     = d;
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      check({tag, "_vld"}, 32'(rsp_valid_o), 32'd1);
      check({tag, "_rd"},  rdata_o, e_rd);
      check({tag, "_err"}, 32'(err_o), 32'(e_err));
      if (w && !model_err(a, s))
         for (int i = 0; i < (1 << s); i++) mem_b[a + i] = d[8*i +: 8];
   endtask

   task automatic model_req(input string tag, input logic w, input logic [31:0] a,
                            input logic [1:0] s, input logic sg, input logic [31:0] d);
      logic        e_err;
      logic [31:0] e_rd;
      e_err = model_err(a, s);
      e_rd  = (w || e_err) ? 32'h0 : model_load(a, s, sg);
      do_req(tag, w, a, s, sg, d, e_rd, e_err);
   endtask

   task automatic idle(input string tag);
      @(negedge clk);
      req_valid_i = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_vld"}, 32'(rsp_valid_o), 32'd0);
      check({tag, "_rd"},  rdata_o, 32'h0);
   endtask

   // Counts cycles from reset release to init_done while offering a store that must be ignored.
   task automatic wait_init(input string tag);
      int   cycles;
      logic saw_rsp;
      cycles  = 0;
      saw_rsp = 1'b0;
      @(negedge clk);
      rst         = 1'b0;
      req_valid_i = 1'b1;
      we_i        = 1'b1;
      addr_i      = 32'h0;
      size_i      = 2'b10;
      wdata_i     = 32'hDEAD_BEEF;
      while (!init_done_o && cycles < 200) begin
         @(posedge clk);
         #1;
         cycles++;
         if (rsp_valid_o || req_ready_o != init_done_o) saw_rsp = 1'b1;
      end
      req_valid_i = 1'b0;
      check({tag, "_cycles"}, 32'(cycles), 32'(DEPTH));
      check({tag, "_ignored"}, 32'(saw_rsp), 32'd0);
      check({tag, "_ready"}, 32'(req_ready_o), 32'd1);
      model_clear();
   endtask

   initial begin
      logic        w, sg;
      logic [1:0]  s;
      logic [31:0] a, d;

      repeat (3) @(posedge clk);
      #1;
      check("rst_vld",   32'(rsp_valid_o), 32'd0);
      check("rst_rd",    rdata_o, 32'h0);
      check("rst_err",   32'(err_o), 32'd0);
      check("rst_done",  32'(init_done_o), 32'd0);
      check("rst_ready", 32'(req_ready_o), 32'd0);

      wait_init("init1");
      do_req("ld_w0",  1'b0, 32'h00, 2'b10, 1'b0, 32'h0, 32'h0000_0000, 1'b0);
      do_req("ld_w31", 1'b0, 32'h7C, 2'b10, 1'b0, 32'h0, 32'h0000_0000, 1'b0);
      idle("idle0");

      do_req("sw10",  1'b1, 32'h10, 2'b10, 1'b0, 32'h8070_60F0, 32'h0, 1'b0);
      do_req("lb10",  1'b0, 32'h10, 2'b00, 1'b1, 32'h0, 32'hFFFF_FFF0, 1'b0);
      do_req("lbu13", 1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 32'h0000_0080, 1'b0);
      do_req("lh12",  1'b0, 32'h12, 2'b01, 1'b1, 32'h0, 32'hFFFF_8070, 1'b0);
      do_req("lhu12", 1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 32'h0000_8070, 1'b0);

      do_req("sw20",  1'b1, 32'h20, 2'b10, 1'b0, 32'h1122_3344, 32'h0, 1'b0);
      do_req("sb21",  1'b1, 32'h21, 2'b00, 1'b0, 32'h0000_00AA, 32'h0, 1'b0);
      do_req("lw20a", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h1122_AA44, 1'b0);
      do_req("sh22",  1'b1, 32'h22, 2'b01, 1'b0, 32'h0000_BEEF, 32'h0, 1'b0);
      do_req("lw20b", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'hBEEF_AA44, 1'b0);

      do_req("e_lw02", 1'b0, 32'h02, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
      do_req("e_lh01", 1'b0, 32'h01, 2'b01, 1'b1, 32'h0, 32'h0, 1'b1);
      do_req("e_sz3",  1'b0, 32'h00, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
      do_req("e_oor",  1'b0, 32'h80, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
      do_req("e_sw02", 1'b1, 32'h02, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
      do_req("e_sw80", 1'b1, 32'h80, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
      do_req("e_ss3",  1'b1, 32'h00, 2'b11, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
      do_req("e_hi",   1'b1, 32'h8000_0000, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
      do_req("unch0",  1'b0, 32'h00, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);

      do_req("b2b_sw", 1'b1, 32'h04, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 1'b0);
      do_req("b2b_lw", 1'b0, 32'h04, 2'b10, 1'b0, 32'h0, 32'h1234_5678, 1'b0);
      idle("idle1");

      for (int it = 0; it < 400; it++) begin
         w  = 1'($urandom_range(0, 1));
         sg = 1'($urandom_range(0, 1));
         s  = 2'($urandom_range(0, 3));
         d  = $urandom;
         a  = $urandom_range(0, NBYTES - 1);
         if (s != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 1);
         if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(7, 31));
         model_req("rnd", w, a, s, sg, d);
         if ($urandom_range(0, 7) == 0) idle("rnd_idle");
      end

      do_req("pre_sw1", 1'b1, 32'h04, 2'b10, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0);
      @(negedge clk);
      req_valid_i = 1'b1;
      we_i        = 1'b0;
      addr_i      = 32'h04;
      size_i      = 2'b10;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_vld",  32'(rsp_valid_o), 32'd0);
      check("mid_rst_rd",   rdata_o, 32'h0);
      check("mid_rst_done", 32'(init_done_o), 32'd0);
      repeat (2) @(posedge clk);
      wait_init("init2");
      do_req("post_w1", 1'b0, 32'h04, 2'b10, 1'b0, 32'h0, 32'h0000_0000, 1'b0);
      idle("idle2");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish, want finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
